// File: rtl/bank_arbiter_pkg.sv
// Shared widths and arbiter state encoding for the bank arbiter.
// Imported by the channel arbiter and the top level.
package bank_arbiter_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bank_arbiter_rr_lock_arb.sv
// Two-way round-robin arbiter with per-requester burst lock.
// Grant is combinational from req, lock, state and pointer only.
module rr_lock_arb
  import bank_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  arb_state_e state;
  arb_state_e state_n;
  logic       ptr;
  logic       ptr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    gnt     = 2'b00;
    state_n = state;
    ptr_n   = ptr;
    unique case (state)
      ARB: begin
        if (req == 2'b11)
          gnt = ptr ? 2'b10 : 2'b01;
        else
          gnt = req;
        if (gnt[0]) begin
          ptr_n = 1'b1;
          if (lock[0]) state_n = LOCK0;
        end
        if (gnt[1]) begin
          ptr_n = 1'b0;
          if (lock[1]) state_n = LOCK1;
        end
      end
      // Owner keeps the lock-drop cycle; pointer frozen until then.
      LOCK0: begin
        gnt[0] = req[0];
        if (!lock[0]) begin
          state_n = ARB;
          ptr_n   = 1'b1;
        end
      end
      LOCK1: begin
        gnt[1] = req[1];
        if (!lock[1]) begin
          state_n = ARB;
          ptr_n   = 1'b0;
        end
      end
      default: state_n = ARB;
    endcase
  end

endmodule

// File: rtl/bank_arbiter.sv
// Read/write arbiter and sequencer for one 1W1R block-RAM bank.
// Holds the bank port registers and the read-owner id pipeline.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr0_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [1:0]        rd_lock_i,
  output logic [1:0]        rd_gnt_o,
  input  logic [1:0]        wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr0_i,
  input  logic [ADDR_W-1:0] wr_addr1_i,
  input  logic [DATA_W-1:0] wr_data0_i,
  input  logic [DATA_W-1:0] wr_data1_i,
  input  logic [1:0]        wr_lock_i,
  output logic [1:0]        wr_gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] bank_waddr_o,
  output logic [ADDR_W-1:0] bank_raddr_o,
  output logic [DATA_W-1:0] bank_wdata_o,
  output logic              bank_wen_o,
  output logic              bank_ren_o,
  output logic              bank_en_o,
  input  logic [DATA_W-1:0] bank_rdata_i
);

  logic [1:0] id_q;

  rr_lock_arb u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (rd_req_i),
    .lock (rd_lock_i),
    .gnt  (rd_gnt_o)
  );

  rr_lock_arb u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req_i),
    .lock (wr_lock_i),
    .gnt  (wr_gnt_o)
  );

  assign rdata_o = bank_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_waddr_o <= '0;
      bank_raddr_o <= '0;
      bank_wdata_o <= '0;
      bank_wen_o   <= 1'b0;
      bank_ren_o   <= 1'b0;
      bank_en_o    <= 1'b0;
      id_q         <= 2'b00;
      rvalid_o     <= 2'b00;
    end else begin
      bank_en_o  <= 1'b1;
      bank_wen_o <= |wr_gnt_o;
      bank_ren_o <= |rd_gnt_o;
      if (|wr_gnt_o) begin
        bank_waddr_o <= wr_gnt_o[1] ? wr_addr1_i : wr_addr0_i;
        bank_wdata_o <= wr_gnt_o[1] ? wr_data1_i : wr_data0_i;
      end
      if (|rd_gnt_o)
        bank_raddr_o <= rd_gnt_o[1] ? rd_addr1_i : rd_addr0_i;
      // Owner id rides alongside the bank's one-cycle read latency.
      id_q     <= rd_gnt_o;
      rvalid_o <= id_q;
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a read-first 1W1R bank model.
// Expected grants and read data are hand-computed per step.
module tb_bank_arbiter;
  import bank_arbiter_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rd_req, rd_lock, rd_gnt;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [1:0]    wr_req, wr_lock, wr_gnt;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] bank_waddr, bank_raddr;
  logic [DW-1:0] bank_wdata;
  logic          bank_wen, bank_ren, bank_en;
  logic [DW-1:0] bank_q;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  logic [1:0]    p1v, p2v;
  logic [DW-1:0] p1d, p2d;

  always #5 clk = ~clk;

  bank_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_i     (rd_req),
    .rd_addr0_i   (rd_addr0),
    .rd_addr1_i   (rd_addr1),
    .rd_lock_i    (rd_lock),
    .rd_gnt_o     (rd_gnt),
    .wr_req_i     (wr_req),
    .wr_addr0_i   (wr_addr0),
    .wr_addr1_i   (wr_addr1),
    .wr_data0_i   (wr_data0),
    .wr_data1_i   (wr_data1),
    .wr_lock_i    (wr_lock),
    .wr_gnt_o     (wr_gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .bank_waddr_o (bank_waddr),
    .bank_raddr_o (bank_raddr),
    .bank_wdata_o (bank_wdata),
    .bank_wen_o   (bank_wen),
    .bank_ren_o   (bank_ren),
    .bank_en_o    (bank_en),
    .bank_rdata_i (bank_q)
  );

  // Read-first bank: both updates are non-blocking on the same edge.
  always @(posedge clk) begin
    if (bank_en && bank_ren) bank_q <= mem[bank_raddr];
    if (bank_en && bank_wen) mem[bank_waddr] <= bank_wdata;
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(16'h1000 + a);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: check grants, clock, then check the bank side.
  task automatic step(input string tag,
                      input logic [1:0] erg,
                      input logic [1:0] ewg,
                      input logic [DW-1:0] erd);
    #1;
    check({tag, ".rd_gnt"}, 32'(rd_gnt), 32'(erg));
    check({tag, ".wr_gnt"}, 32'(wr_gnt), 32'(ewg));
    @(posedge clk);
    #1;
    p2v = p1v;
    p2d = p1d;
    p1v = erg;
    p1d = erd;
    check({tag, ".ren"}, 32'(bank_ren), 32'(erg != 2'b00));
    check({tag, ".wen"}, 32'(bank_wen), 32'(ewg != 2'b00));
    check({tag, ".rvalid"}, 32'(rvalid), 32'(p2v));
    if (p2v != 2'b00)
      check({tag, ".rdata"}, 32'(rdata), 32'(p2d));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(i);
    bank_q   = '0;
    rst      = 1'b1;
    rd_req   = 2'b00;
    rd_lock  = 2'b00;
    rd_addr0 = '0;
    rd_addr1 = '0;
    wr_req   = 2'b00;
    wr_lock  = 2'b00;
    wr_addr0 = '0;
    wr_addr1 = '0;
    wr_data0 = '0;
    wr_data1 = '0;
    p1v = 2'b00; p2v = 2'b00;
    p1d = '0;    p2d = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.en", 32'(bank_en), 32'd0);
    check("rst.ren", 32'(bank_ren), 32'd0);
    check("rst.wen", 32'(bank_wen), 32'd0);
    check("rst.rvalid", 32'(rvalid), 32'd0);
    check("rst.raddr", 32'(bank_raddr), 32'd0);
    check("rst.waddr", 32'(bank_waddr), 32'd0);
    check("rst.wdata", 32'(bank_wdata), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.en_rise", 32'(bank_en), 32'd1);

    // Alternating reads from both requesters
    rd_req = 2'b11; rd_addr0 = 8'd1; rd_addr1 = 8'd2;
    step("alt0", 2'b01, 2'b00, init_word(1));
    step("alt1", 2'b10, 2'b00, init_word(2));
    step("alt2", 2'b01, 2'b00, init_word(1));
    step("alt3", 2'b10, 2'b00, init_word(2));
    rd_req = 2'b00;
    step("alt_d0", 2'b00, 2'b00, '0);
    step("alt_d1", 2'b00, 2'b00, '0);

    // Write then read-after-write on the next cycle
    wr_req = 2'b10; wr_addr1 = 8'd3; wr_data1 = 16'h00A5;
    step("raw_w", 2'b00, 2'b10, '0);
    check("raw.waddr", 32'(bank_waddr), 32'd3);
    check("raw.wdata", 32'(bank_wdata), 32'h00A5);
    wr_req = 2'b00;
    rd_req = 2'b01; rd_addr0 = 8'd3;
    step("raw_r", 2'b01, 2'b00, 16'h00A5);
    rd_req = 2'b00;
    step("raw_d0", 2'b00, 2'b00, '0);
    step("raw_d1", 2'b00, 2'b00, '0);

    // Same-cycle read and write to one address: read-first
    rd_req = 2'b01; rd_addr0 = 8'd3;
    wr_req = 2'b10; wr_addr1 = 8'd3; wr_data1 = 16'h005A;
    step("rf0", 2'b01, 2'b10, 16'h00A5);
    wr_req = 2'b00;
    step("rf1", 2'b01, 2'b00, 16'h005A);
    rd_req = 2'b00;
    step("rf_d0", 2'b00, 2'b00, '0);
    step("rf_d1", 2'b00, 2'b00, '0);

    // Write burst lock by requester 1
    wr_req = 2'b01; wr_addr0 = 8'd10; wr_data0 = 16'h1111;
    step("lk_pre", 2'b00, 2'b01, '0);
    wr_req = 2'b11; wr_lock = 2'b10;
    for (int i = 0; i < 4; i++) begin
      wr_addr1 = AW'(20 + i);
      wr_data1 = DW'(16'hB000 + i);
      step($sformatf("lk%0d", i), 2'b00, 2'b10, '0);
    end
    wr_lock = 2'b00; wr_addr1 = 8'd24; wr_data1 = 16'hB004;
    step("lk_drop", 2'b00, 2'b10, '0);
    check("lk.waddr", 32'(bank_waddr), 32'd24);
    step("lk_next", 2'b00, 2'b01, '0);
    check("lk.wdata", 32'(bank_wdata), 32'h1111);
    wr_req = 2'b00;

    // Single requester granted every cycle
    rd_req = 2'b10; rd_addr1 = 8'd5;
    step("one0", 2'b10, 2'b00, init_word(5));
    step("one1", 2'b10, 2'b00, init_word(5));
    step("one2", 2'b10, 2'b00, init_word(5));
    rd_req = 2'b00;
    step("one_d0", 2'b00, 2'b00, '0);
    step("one_d1", 2'b00, 2'b00, '0);

    // Reset right after a read grant flushes it
    rd_req = 2'b01; rd_addr0 = 8'd6;
    step("fl_g", 2'b01, 2'b00, init_word(6));
    rd_req = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("fl.rvalid", 32'(rvalid), 32'd0);
    check("fl.en", 32'(bank_en), 32'd0);
    check("fl.ren", 32'(bank_ren), 32'd0);
    check("fl.raddr", 32'(bank_raddr), 32'd0);
    p1v = 2'b00; p2v = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("fl.en_rise", 32'(bank_en), 32'd1);
    check("fl.rvalid2", 32'(rvalid), 32'd0);
    rd_req = 2'b11; rd_addr0 = 8'd7; rd_addr1 = 8'd8;
    step("pr0", 2'b01, 2'b00, init_word(7));
    step("pr1", 2'b10, 2'b00, init_word(8));
    rd_req = 2'b00;
    step("pr_d0", 2'b00, 2'b00, '0);
    step("pr_d1", 2'b00, 2'b00, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
